// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver with 2-FF input synchroniser,
// start/parity/stop validation and a valid/ready output with per-word error
// flags. Define UART_RX_FIFO_EN to get a FIFO_DEPTH-entry first-word-fall-
// through queue; otherwise a single holding register buffers one word.
module uart_rx_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam int WW = DATA_BITS + 2;
    // The start counter is loaded one short because the edge is only seen a
    // cycle after the synchronised line has fallen.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_core: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_core: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_core: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               state, next_state;
    logic                 sync_a, sync_b, line_prev, fall;
    logic [CW-1:0]        cnt, cnt_next;
    logic [BW-1:0]        bit_idx, bit_next;
    logic [DATA_BITS-1:0] shift;
    logic                 shift_en, parity_err, perr_next, tick;
    logic                 push;
    logic [WW-1:0]        push_word, head;
    logic                 pop, accept;

    // Bring the asynchronous line into the clock domain and remember the
    // previous synchronised level for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_a    <= uart_rx;
            sync_b    <= sync_a;
            line_prev <= sync_b;
        end
    end

    assign fall = line_prev & ~sync_b;
    assign tick = (cnt <= CW'(1));

    // Receiver state, baud counter, bit index and data shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_err <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            parity_err <= perr_next;
            if (shift_en) begin
                shift <= {sync_b, shift[DATA_BITS-1:1]};
            end
        end
    end

    // Frame sequencing: decide where each bit-centre sample goes.
    always_comb begin
        next_state = state;
        cnt_next   = (cnt != '0) ? cnt - CW'(1) : '0;
        bit_next   = bit_idx;
        perr_next  = parity_err;
        shift_en   = 1'b0;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (fall) begin
                    next_state = S_START;
                    cnt_next   = HALF_LOAD;
                    perr_next  = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!sync_b) begin
                        next_state = S_DATA;
                        cnt_next   = FULL_LOAD;
                        bit_next   = '0;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    cnt_next = FULL_LOAD;
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        next_state = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_idx + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_next   = FULL_LOAD;
                    perr_next  = (PARITY == 1) ? ~(^shift ^ sync_b) : (^shift ^ sync_b);
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    push       = 1'b1;
                    next_state = (!sync_b && shift == '0) ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK: begin
                if (sync_b) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign push_word = {~sync_b, parity_err, shift};
    assign pop       = rx_valid & rx_ready;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign accept = push & (~full | pop);

    // Queue pointers; the extra top bit tells full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
        end
    end

    // Queue storage, written only when a completed word is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr[AW-1:0]] <= push_word;
        end
    end

    assign head       = empty ? '0 : mem[rptr[AW-1:0]];
    assign rx_valid   = ~empty;
    assign rx_overrun = push & full & ~pop;
`else
    logic [WW-1:0] hold_word;
    logic          hold_valid;

    assign accept = push & (~hold_valid | pop);

    // Single holding register standing in for the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_word  <= '0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_word  <= push_word;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign head       = hold_valid ? hold_word : '0;
    assign rx_valid   = hold_valid;
    assign rx_overrun = push & hold_valid & ~pop;
`endif

    assign rx_data       = head[DATA_BITS-1:0];
    assign rx_parity_err = head[DATA_BITS];
    assign rx_frame_err  = head[DATA_BITS+1];
    assign rx_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: three receivers (no parity, odd, even + two stop bits)
// driven by a serial line generator and checked against a word queue model.
module tb_uart_rx_core;

    localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       line  [3];
    logic       ready [3];
    logic [7:0] data  [3];
    logic       pe    [3];
    logic       fe    [3];
    logic       valid [3];
    logic       ovr   [3];
    logic       busy  [3];

    int         n_assert = 0;
    int         n_fail = 0;
    int         ovr_cnt [3] = '{0, 0, 0};
    int         exp_ovr [3] = '{0, 0, 0};
    logic [9:0] mq [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_core #(
            .CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8),
            .PARITY(g), .STOP_BITS((g == 2) ? 2 : 1), .FIFO_DEPTH(4)
        ) dut (
            .clk(clk), .reset(reset), .uart_rx(line[g]),
            .rx_data(data[g]), .rx_parity_err(pe[g]), .rx_frame_err(fe[g]),
            .rx_valid(valid[g]), .rx_ready(ready[g]),
            .rx_overrun(ovr[g]), .rx_busy(busy[g])
        );
    end

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (ovr[g] === 1'b1) ovr_cnt[g]++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {frame_err, parity_err, data} from the bits on the wire.
    function automatic logic [9:0] frame_word(input int ch, input logic [7:0] d,
                                              input logic pbit, input logic stop);
        int   ones;
        logic perr;
        ones = $countones(d) + int'(pbit);
        perr = 1'b0;
        if (ch == 1) perr = (ones % 2 == 0);
        if (ch == 2) perr = (ones % 2 == 1);
        return {~stop, perr, d};
    endfunction

    task automatic model_push(input int ch, input logic [9:0] w);
        if (mq.size() < CAP) mq.push_back(w);
        else exp_ovr[ch]++;
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] d,
                                 input logic flip, input logic stop);
        logic [11:0] bits;
        logic        pbit;
        int          n;
        pbit = ((ch == 1) ? ~^d : ^d) ^ flip;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
        if (ch != 0) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = stop;
        n++;
        if (ch == 2) begin
            bits[n] = 1'b1;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            line[ch] = bits[i];
            repeat (CPB) @(negedge clk);
        end
        line[ch] = 1'b1;
        repeat (CPB) @(negedge clk);
        model_push(ch, frame_word(ch, d, (ch == 0) ? 1'b0 : pbit, stop));
    endtask

    task automatic checkOutput(input int ch);
        logic [9:0] w;
        int         k;
        k = 0;
        while (valid[ch] !== 1'b1 && k < 4 * CPB) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("ch%0d_valid", ch), 32'(valid[ch]), 32'd1);
        w = (mq.size() != 0) ? mq.pop_front() : 10'h3ff;
        check($sformatf("ch%0d_data", ch), 32'(data[ch]), 32'(w[7:0]));
        check($sformatf("ch%0d_parity_err", ch), 32'(pe[ch]), 32'(w[8]));
        check($sformatf("ch%0d_frame_err", ch), 32'(fe[ch]), 32'(w[9]));
        ready[ch] = 1'b1;
        @(negedge clk);
        ready[ch] = 1'b0;
        check($sformatf("ch%0d_valid_after_pop", ch), 32'(valid[ch]),
              32'(mq.size() != 0));
    endtask

    task automatic check_reset_values();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_ch%0d_valid", g), 32'(valid[g]), 32'd0);
            check($sformatf("rst_ch%0d_busy", g), 32'(busy[g]), 32'd0);
            check($sformatf("rst_ch%0d_overrun", g), 32'(ovr[g]), 32'd0);
            check($sformatf("rst_ch%0d_data", g), 32'(data[g]), 32'd0);
            check($sformatf("rst_ch%0d_parity_err", g), 32'(pe[g]), 32'd0);
            check($sformatf("rst_ch%0d_frame_err", g), 32'(fe[g]), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] a5;
        for (int g = 0; g < 3; g++) begin
            line[g]  = 1'b1;
            ready[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] nominal frame");
        applyStimulus(0, 8'h30, 1'b0, 1'b1);
        checkOutput(0);

        $display("[TB] parity frames");
        applyStimulus(2, 8'h31, 1'b0, 1'b1);
        checkOutput(2);
        applyStimulus(2, 8'h31, 1'b1, 1'b1);
        checkOutput(2);
        applyStimulus(1, 8'h31, 1'b0, 1'b1);
        checkOutput(1);
        applyStimulus(1, 8'h31, 1'b1, 1'b1);
        checkOutput(1);

        $display("[TB] random frames");
        for (int k = 0; k < 9; k++) begin
            d = 8'($urandom);
            applyStimulus(k % 3, d, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0));
            checkOutput(k % 3);
        end

        $display("[TB] glitch rejection");
        line[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", 32'(busy[0]), 32'd1);
        line[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_busy_low", 32'(busy[0]), 32'd0);
        check("glitch_no_push", 32'(valid[0]), 32'd0);

        $display("[TB] overrun");
        for (int k = 0; k <= CAP; k++) begin
            applyStimulus(0, 8'(8'h41 + k), 1'b0, 1'b1);
        end
        repeat (2) @(negedge clk);
        check("overrun_pulses", 32'(ovr_cnt[0]), 32'(exp_ovr[0]));
        for (int k = 0; k < CAP; k++) checkOutput(0);

        $display("[TB] framing and break");
        applyStimulus(0, 8'h55, 1'b0, 1'b0);
        checkOutput(0);
        line[0] = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        check("break_busy", 32'(busy[0]), 32'd1);
        repeat (5 * CPB) @(negedge clk);
        line[0] = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        model_push(0, frame_word(0, 8'h00, 1'b0, 1'b0));
        checkOutput(0);
        applyStimulus(0, 8'h7E, 1'b0, 1'b1);
        checkOutput(0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h3C, 1'b0, 1'b1);
        a5 = 8'hA5;
        line[0] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            line[0] = a5[i];
            repeat (CPB) @(negedge clk);
        end
        line[0] = a5[3];
        repeat (CPB / 2) @(negedge clk);
        check("midframe_busy", 32'(busy[0]), 32'd1);
        check("midframe_held_word", 32'(valid[0]), 32'd1);
        reset = 1'b0;
        line[0] = 1'b1;
        @(negedge clk);
        check_reset_values();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mq.delete();
        repeat (2 * CPB) @(negedge clk);
        check("post_reset_no_push", 32'(valid[0]), 32'd0);
        applyStimulus(0, 8'h5A, 1'b0, 1'b1);
        checkOutput(0);

        repeat (4) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("ch%0d_overrun_total", g), 32'(ovr_cnt[g]), 32'(exp_ovr[g]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
